alu_seq_unit: RTL and testbench

- Execute-stage ALU that sits directly downstream of the ALU control unit and consumes its 4-bit ALUOperation code.
- Single-cycle ops (logic, add/sub, LUI, branch compare) complete in 1 cycle.
- SLL/SRL run as an iterative 1-bit-per-cycle shifter, which removes the barrel shifter from the critical path.
- Start/busy/done handshake toward the datapath sequencer; registered result and Zero flag.

---
 rtl/alu_seq_unit.sv | 188 ++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// alu_seq_unit
// Execute-stage ALU fed by the ALU control unit's 4-bit ALUOperation code.
// Logic, add/sub, LUI and branch-compare ops finish one edge after start.
// SLL/SRL use an iterative shifter that moves 1 bit per cycle, so there is
// no barrel shifter on the critical path.
//
// Optional feature: define ALU_OVERFLOW_EN to register a signed-overflow
// flag for ADD (0011) and SUB (0100). Without the macro, Overflow is tied 0.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        operation request, sampled only while idle
//   ALUOperation 4-bit op code (captured at the start edge)
//   A, B         operands (captured at the start edge)
//   shamt        shift amount for SLL/SRL (captured at the start edge)
//   busy         high while an iterative shift is in flight
//   done         one-cycle pulse; ALUResult/Zero/Overflow valid from here on
//   ALUResult    registered result, held until the next completion
//   Zero         registered (ALUResult == 0)
//   Overflow     registered signed overflow (ALU_OVERFLOW_EN only)
module alu_seq_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ALUOperation,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  ALUResult,
  output logic                   Zero,
  output logic                   Overflow
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;

  localparam int LUI_PAD = DATA_WIDTH - 16;

`ifdef ALU_OVERFLOW_EN
  // Signed overflow: operands with compatible signs (equal for ADD, opposite
  // for SUB) whose wrapped result flips away from A's sign.
  function automatic logic ovf_detect(input logic signed [DATA_WIDTH-1:0] a,
                                      input logic signed [DATA_WIDTH-1:0] b,
                                      input logic signed [DATA_WIDTH-1:0] r,
                                      input logic                         is_sub);
    logic sign_ok;
    sign_ok = is_sub ? (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
                     : (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]);
    return sign_ok && (r[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
  endfunction
`endif

  logic [0:0]                   state;
  logic [DATA_WIDTH-1:0]        work_p1;
  logic [SHAMT_WIDTH-1:0]       cnt_p1;
  logic                         dir_right_p1;

  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;
  logic signed [DATA_WIDTH-1:0] sum_p0;
  logic signed [DATA_WIDTH-1:0] diff_p0;
  logic [DATA_WIDTH-1:0]        result_p0;
  logic                         ovf_p0;
  logic                         is_shift_op;

  // ---- stage p0: combinational single-cycle result from live operands ----
  assign a_s         = A;
  assign b_s         = B;
  assign sum_p0      = a_s + b_s;
  assign diff_p0     = a_s - b_s;
  assign is_shift_op = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);

  always_comb begin
    result_p0 = '0;
    ovf_p0    = 1'b0;
    case (ALUOperation)
      OP_AND: result_p0 = A & B;
      OP_OR:  result_p0 = A | B;
      OP_NOR: result_p0 = ~(A | B);
      OP_ADD: begin
        result_p0 = sum_p0;
`ifdef ALU_OVERFLOW_EN
        ovf_p0    = ovf_detect(a_s, b_s, sum_p0, 1'b0);
`endif
      end
      OP_SUB: begin
        result_p0 = diff_p0;
`ifdef ALU_OVERFLOW_EN
        ovf_p0    = ovf_detect(a_s, b_s, diff_p0, 1'b1);
`endif
      end
      OP_LUI: result_p0 = {B[15:0], {LUI_PAD{1'b0}}};
      OP_BEQ: result_p0 = diff_p0;
      default: result_p0 = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_p1;
  assign Overflow = ovf_p1;
`else
  assign Overflow = 1'b0;
`endif

  // ---- stage p1: registered result and iterative shifter ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      ALUResult    <= '0;
      Zero         <= 1'b0;
      work_p1      <= '0;
      cnt_p1       <= '0;
      dir_right_p1 <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_p1       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_shift_op) begin
              // Capture everything the shift needs; A/B/op may change freely
              // while the shift runs.
              work_p1      <= B;
              cnt_p1       <= shamt;
              dir_right_p1 <= ALUOperation[0];
              busy         <= 1'b1;
              state        <= ST_SHIFT;
            end else begin
              ALUResult <= result_p0;
              Zero      <= (result_p0 == '0);
              done      <= 1'b1;
`ifdef ALU_OVERFLOW_EN
              ovf_p1    <= ovf_p0;
`endif
            end
          end
        end
        ST_SHIFT: begin
          if (cnt_p1 != '0) begin
            work_p1 <= dir_right_p1 ? (work_p1 >> 1) : (work_p1 << 1);
            cnt_p1  <= cnt_p1 - 1'b1;
          end else begin
            ALUResult <= work_p1;
            Zero      <= (work_p1 == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
`ifdef ALU_OVERFLOW_EN
            ovf_p1    <= 1'b0;
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef ALU_OVERFLOW_EN
  // Overflow detection is absent in this build; keep the unused p0 flag
  // visible to lint as intentionally consumed.
  logic unused_ovf;
  assign unused_ovf = ovf_p0;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;
  localparam int DW = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    op = '0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic [SW-1:0] sh = '0;
  logic          busy, done, zero, ovf;
  logic [DW-1:0] res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOperation(op),
    .A(a), .B(b), .shamt(sh), .busy(busy), .done(done),
    .ALUResult(res), .Zero(zero), .Overflow(ovf)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic [31:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input int s);
    case (o)
      4'd0: return x & y;
      4'd1: return x | y;
      4'd2: return ~(x | y);
      4'd3: return x + y;
      4'd4: return x - y;
      4'd5: return y << 16;
      4'd6: return y << s;
      4'd7: return y >> s;
      4'd8: return x - y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef ALU_OVERFLOW_EN
    longint sx, sy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 4'd3) r = sx + sy;
    else if (o == 4'd4) r = sx - sy;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
    return 1'b0;
`endif
  endfunction

  int          m_left = 0;
  logic [31:0] m_pend = '0, m_res = '0;
  logic        m_done = 1'b0, m_busy = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;

  // A shift with amount s finishes s+1 edges after it is accepted.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0; m_pend = '0; m_res = '0;
      m_done = 1'b0; m_busy = 1'b0; m_zero = 1'b0; m_ovf = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_res = m_pend; m_zero = (m_pend == 0); m_ovf = 1'b0;
          m_done = 1'b1; m_busy = 1'b0;
        end
      end else if (start) begin
        if (op == 4'd6 || op == 4'd7) begin
          m_pend = ref_result(op, a, b, int'(sh));
          m_left = int'(sh) + 1;
          m_busy = 1'b1;
        end else begin
          m_res  = ref_result(op, a, b, 0);
          m_zero = (m_res == 0);
          m_ovf  = ref_ovf(op, a, b);
          m_done = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("done", {31'd0, done}, {31'd0, m_done});
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("result", res, m_res);
    check("zero", {31'd0, zero}, {31'd0, m_zero});
    check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] s, output int lat, output int bc,
                        output logic [31:0] r, output logic z, output logic v);
    @(negedge clk);
    op = o; a = av; b = bv; sh = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; bc = 0;
    while (!done && lat < 100) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check("timeout", 32'd1, 32'd0);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    r = res; z = zero; v = ovf;
  endtask

  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  int          lat, bc, pulses, first_k, second_k;
  logic [31:0] r, first_r, second_r;
  logic        z, v;
  logic        exp_v;

  initial begin
`ifdef ALU_OVERFLOW_EN
    exp_v = 1'b1;
`else
    exp_v = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", res, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    reset = 1'b1;

    run_op(4'd3, 32'h5, 32'h3, 5'd0, lat, bc, r, z, v);
    check("add_lat", lat, 0); check("add_busy", bc, 0);
    check("add_res", r, 32'd8); check("add_zero", {31'd0, z}, 32'd0);

    // Reset in the middle of a long shift.
    @(negedge clk);
    op = 4'd6; a = '0; b = 32'h1; sh = 5'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_res", res, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    run_op(4'd3, 32'h1, 32'h1, 5'd0, lat, bc, r, z, v);
    check("post_rst_add", r, 32'd2);

    run_op(4'd6, 32'h0, 32'h1, 5'd31, lat, bc, r, z, v);
    check("sll31_lat", lat, 32); check("sll31_busy", bc, 32); check("sll31_res", r, 32'h8000_0000);
    run_op(4'd7, 32'h0, 32'h8000_0000, 5'd4, lat, bc, r, z, v);
    check("srl4_lat", lat, 5); check("srl4_res", r, 32'h0800_0000);
    run_op(4'd6, 32'h0, 32'hDEAD_BEEF, 5'd0, lat, bc, r, z, v);
    check("sll0_lat", lat, 1); check("sll0_res", r, 32'hDEAD_BEEF);
    run_op(4'd8, 32'h1234_5678, 32'h1234_5678, 5'd0, lat, bc, r, z, v);
    check("beq_res", r, 32'd0); check("beq_zero", {31'd0, z}, 32'd1);
    run_op(4'd5, 32'hFFFF_FFFF, 32'h0000_ABCD, 5'd0, lat, bc, r, z, v);
    check("lui_res", r, 32'hABCD_0000);
    run_op(4'd15, 32'h1111_1111, 32'h2222_2222, 5'd3, lat, bc, r, z, v);
    check("op15_res", r, 32'd0); check("op15_zero", {31'd0, z}, 32'd1);
    run_op(4'd0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, lat, bc, r, z, v);
    check("and_res", r, 32'h00F0_000F);
    run_op(4'd1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, lat, bc, r, z, v);
    check("or_res", r, 32'hFFF0_0FFF);
    run_op(4'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, lat, bc, r, z, v);
    check("nor_res", r, 32'h000F_F000);
    run_op(4'd3, 32'h7FFF_FFFF, 32'h1, 5'd0, lat, bc, r, z, v);
    check("addovf_res", r, 32'h8000_0000); check("addovf_flag", {31'd0, v}, {31'd0, exp_v});
    run_op(4'd4, 32'h8000_0000, 32'h1, 5'd0, lat, bc, r, z, v);
    check("subovf_res", r, 32'h7FFF_FFFF); check("subovf_flag", {31'd0, v}, {31'd0, exp_v});
    run_op(4'd6, 32'h0, 32'h3, 5'd1, lat, bc, r, z, v);
    check("sll_clears_ovf", {31'd0, v}, 32'd0);

    // start held high through a shamt=3 shift while op/operands change.
    @(negedge clk);
    op = 4'd6; a = '0; b = 32'h5; sh = 5'd3; start = 1'b1;
    @(negedge clk);
    first_k = -1; second_k = -1; first_r = '0; second_r = '0;
    for (int k = 0; k < 8; k++) begin
      if (done && first_k < 0) begin first_k = k; first_r = res; end
      else if (done && second_k < 0) begin second_k = k; second_r = res; end
      if (k < 2) begin op = 4'd7; b = $urandom; sh = 5'd1; end
      else begin op = 4'd3; a = 32'd10; b = 32'd20; end
      @(negedge clk);
    end
    start = 1'b0;
    check("hs_first_k", first_k, 4); check("hs_first_r", first_r, 32'd40);
    check("hs_second_k", second_k, 5); check("hs_second_r", second_r, 32'd30);

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 149) != 0);
      start = $urandom_range(0, 1);
      op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      a     = pick_operand();
      b     = pick_operand();
      sh    = 5'($urandom);
    end
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
